// File: rtl/tile_reset_sequencer.sv
// Tile reset sequencer: power-on and software-requested reset with quiesce, clock gating and settle window.
// Optional statistics counters are built when TILE_RESET_SEQ_STATS_EN is defined.
module tile_reset_sequencer #(
  parameter int HOLD_CYCLES     = 8,
  parameter int SETTLE_CYCLES   = 4,
  parameter int QUIESCE_TIMEOUT = 64,
  parameter int CNT_W           = 8
) (
  input  logic clk_in,
  input  logic rst_n,
  input  logic req_valid,
  output logic req_ready,
  output logic quiesce_req,
  input  logic quiesce_ack,
  output logic tile_reset,
  output logic tile_clk_en,
  output logic running,
  output logic timed_out
`ifdef TILE_RESET_SEQ_STATS_EN
  ,
  output logic [7:0] reset_count,
  output logic [7:0] timeout_count
`endif
);

  typedef enum logic [2:0] {
    S_HOLD,
    S_SETTLE,
    S_RUN,
    S_QUIESCE,
    S_GATE
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(QUIESCE_TIMEOUT - 1);

  state_t           state;
  logic [CNT_W-1:0] count;
  logic             ack_meta;
  logic             ack_sync;

  // quiesce_ack comes from the tile's own timing domain
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      ack_meta <= 1'b0;
      ack_sync <= 1'b0;
    end else begin
      ack_meta <= quiesce_ack;
      ack_sync <= ack_meta;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_HOLD;
      count       <= '0;
      tile_reset  <= 1'b1;
      tile_clk_en <= 1'b1;
      quiesce_req <= 1'b0;
      req_ready   <= 1'b0;
      running     <= 1'b0;
      timed_out   <= 1'b0;
    end else begin
      timed_out <= 1'b0;
      case (state)
        S_HOLD: begin
          if (count == HOLD_LAST) begin
            count      <= '0;
            tile_reset <= 1'b0;
            if (SETTLE_CYCLES == 0) begin
              state     <= S_RUN;
              running   <= 1'b1;
              req_ready <= 1'b1;
            end else begin
              state <= S_SETTLE;
            end
          end else begin
            count <= count + CNT_W'(1);
          end
        end
        S_SETTLE: begin
          if (count == SETTLE_LAST) begin
            count     <= '0;
            state     <= S_RUN;
            running   <= 1'b1;
            req_ready <= 1'b1;
          end else begin
            count <= count + CNT_W'(1);
          end
        end
        S_RUN: begin
          if (req_valid && req_ready) begin
            state       <= S_QUIESCE;
            count       <= '0;
            running     <= 1'b0;
            req_ready   <= 1'b0;
            quiesce_req <= 1'b1;
          end
        end
        S_QUIESCE: begin
          // A synced ack on the final wait cycle counts as a clean drain
          if (ack_sync || (count == TIMEOUT_LAST)) begin
            state       <= S_GATE;
            count       <= '0;
            quiesce_req <= 1'b0;
            tile_clk_en <= 1'b0;
            tile_reset  <= 1'b1;
            timed_out   <= !ack_sync;
          end else begin
            count <= count + CNT_W'(1);
          end
        end
        S_GATE: begin
          state       <= S_HOLD;
          count       <= '0;
          tile_clk_en <= 1'b1;
        end
        default: begin
          state       <= S_HOLD;
          count       <= '0;
          tile_reset  <= 1'b1;
          tile_clk_en <= 1'b1;
          quiesce_req <= 1'b0;
          req_ready   <= 1'b0;
          running     <= 1'b0;
        end
      endcase
    end
  end

`ifdef TILE_RESET_SEQ_STATS_EN
  // Saturating event counters, cleared only by rst_n
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      reset_count   <= '0;
      timeout_count <= '0;
    end else begin
      if ((state == S_GATE) && (reset_count != 8'hFF)) begin
        reset_count <= reset_count + 8'd1;
      end
      if ((state == S_QUIESCE) && !ack_sync && (count == TIMEOUT_LAST) &&
          (timeout_count != 8'hFF)) begin
        timeout_count <= timeout_count + 8'd1;
      end
    end
  end
`endif

endmodule
